// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter
//   Shares one FPU between two requesters. Round-robin arbitration picks a
//   winner in IDLE. The winner's operands and opcode are registered into the
//   FPU and the operation is sequenced:
//     - ADD/SUB (and any unknown opcode): one settle cycle, then capture.
//     - MUL/DIV: start pulse, then wait for the matching done.
//   A watchdog turns a hung MUL/DIV into an error response (QNAN, NV flag).
//
// Ports
//   clock, resetN          clock, asynchronous active-low reset
//   req{0,1}Valid/Ready    requester handshakes (Ready is combinational)
//   req{0,1}In1/In2/Op     requester operands and opcode
//   rspValid/rspReady      response handshake
//   rspId/Result/Flags/Err response payload
//   fpuIn1/In2/Op          registered operands/opcode driven to the FPU
//   fpuStart               one-cycle start pulse for MUL/DIV
//   fpuMulDone/DivDone     FPU completion strobes
//   fpuOut/fpuFlags        FPU result and status flags

package fpu_pkg;
    typedef logic [15:0] fp16_t;
    typedef logic [2:0]  fpuOp_t;

    localparam fpuOp_t FPU_ADD = 3'd0;
    localparam fpuOp_t FPU_SUB = 3'd1;
    localparam fpuOp_t FPU_MUL = 3'd2;
    localparam fpuOp_t FPU_DIV = 3'd3;

    typedef struct packed {
        logic nv;   // invalid operation
        logic dz;   // divide by zero
        logic of;   // overflow
        logic uf;   // underflow
        logic nx;   // inexact
    } statusFlag_t;
endpackage

module fpu_req_arbiter
    import fpu_pkg::*;
#(
    parameter type         FP_T    = fp16_t,
    parameter int unsigned TIMEOUT = 64,        // must be >= 2
    parameter FP_T         QNAN    = 16'h7E00
) (
    input  logic        clock,
    input  logic        resetN,

    input  logic        req0Valid,
    output logic        req0Ready,
    input  FP_T         req0In1,
    input  FP_T         req0In2,
    input  fpuOp_t      req0Op,

    input  logic        req1Valid,
    output logic        req1Ready,
    input  FP_T         req1In1,
    input  FP_T         req1In2,
    input  fpuOp_t      req1Op,

    output logic        rspValid,
    input  logic        rspReady,
    output logic        rspId,
    output FP_T         rspResult,
    output statusFlag_t rspFlags,
    output logic        rspErr,

    output FP_T         fpuIn1,
    output FP_T         fpuIn2,
    output fpuOp_t      fpuOp,
    output logic        fpuStart,
    input  logic        fpuMulDone,
    input  logic        fpuDivDone,
    input  FP_T         fpuOut,
    input  statusFlag_t fpuFlags
);

    localparam int CW = $clog2(TIMEOUT);
    localparam statusFlag_t TIMEOUT_FLAGS = '{nv: 1'b1, default: 1'b0};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t          state, stateNext;
    logic            lastGrant;
    logic [CW-1:0]   wdCnt;

    logic            anyValid;
    logic            winId;
    fpuOp_t          winOp;
    logic            fpuDone;
    logic            wdExpired;

    function automatic logic isLong(input fpuOp_t op);
        return (op == FPU_MUL) || (op == FPU_DIV);
    endfunction

    // Single valid requester wins outright; on a tie the one that did not
    // win last time is chosen.
    assign anyValid  = req0Valid || req1Valid;
    assign winId     = (req0Valid && req1Valid) ? ~lastGrant : req1Valid;
    assign winOp     = winId ? req1Op : req0Op;

    // Only MUL or DIV can be latched while in WAIT, so the other done is
    // never looked at.
    assign fpuDone   = (fpuOp == FPU_MUL) ? fpuMulDone : fpuDivDone;
    assign wdExpired = (wdCnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        req0Ready = 1'b0;
        req1Ready = 1'b0;
        fpuStart  = 1'b0;
        rspValid  = 1'b0;
        unique case (state)
            IDLE: begin
                // Gated by resetN so Ready reads 0 while reset is held.
                req0Ready = resetN && anyValid && !winId;
                req1Ready = resetN && anyValid &&  winId;
                if (anyValid) stateNext = isLong(winOp) ? START : SETTLE;
            end
            SETTLE: stateNext = RESP;
            START: begin
                fpuStart  = 1'b1;
                stateNext = WAIT;
            end
            WAIT: if (fpuDone || wdExpired) stateNext = RESP;
            RESP: begin
                rspValid = 1'b1;
                if (rspReady) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            lastGrant <= 1'b1;
            wdCnt     <= '0;
            fpuIn1    <= '0;
            fpuIn2    <= '0;
            fpuOp     <= '0;
            rspId     <= 1'b0;
            rspResult <= '0;
            rspFlags  <= '0;
            rspErr    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (anyValid) begin
                    fpuIn1    <= winId ? req1In1 : req0In1;
                    fpuIn2    <= winId ? req1In2 : req0In2;
                    fpuOp     <= winOp;
                    rspId     <= winId;
                    lastGrant <= winId;
                end
                SETTLE: begin
                    rspResult <= fpuOut;
                    rspFlags  <= fpuFlags;
                    rspErr    <= 1'b0;
                end
                START: wdCnt <= '0;
                WAIT: begin
                    wdCnt <= wdCnt + 1'b1;
                    // done takes priority over a coincident timeout
                    if (fpuDone) begin
                        rspResult <= fpuOut;
                        rspFlags  <= fpuFlags;
                        rspErr    <= 1'b0;
                    end else if (wdExpired) begin
                        rspResult <= QNAN;
                        rspFlags  <= TIMEOUT_FLAGS;
                        rspErr    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// tb_fpu_req_arbiter
//   Drives the arbiter with two requester tasks and a behavioural FPU stub.
//   Expected responses are queued when stimulus is issued and compared when
//   the response handshake occurs.
module tb_fpu_req_arbiter;
    import fpu_pkg::*;

    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        req0Valid = 1'b0, req1Valid = 1'b0;
    logic        req0Ready, req1Ready;
    fp16_t       req0In1 = '0, req0In2 = '0, req1In1 = '0, req1In2 = '0;
    fpuOp_t      req0Op = '0, req1Op = '0;
    logic        rspValid, rspId, rspErr;
    logic        rspReady = 1'b0;
    fp16_t       rspResult;
    statusFlag_t rspFlags;
    fp16_t       fpuIn1, fpuIn2, fpuOut;
    fpuOp_t      fpuOp;
    logic        fpuStart;
    logic        fpuMulDone = 1'b0, fpuDivDone = 1'b0;
    statusFlag_t fpuFlags;
    statusFlag_t stubFlags = 5'b00001;

    fpu_req_arbiter #(.FP_T(fp16_t), .TIMEOUT(TO), .QNAN(16'h7E00)) dut (
        .clock(clock), .resetN(resetN),
        .req0Valid(req0Valid), .req0Ready(req0Ready), .req0In1(req0In1), .req0In2(req0In2), .req0Op(req0Op),
        .req1Valid(req1Valid), .req1Ready(req1Ready), .req1In1(req1In1), .req1In2(req1In2), .req1Op(req1Op),
        .rspValid(rspValid), .rspReady(rspReady), .rspId(rspId), .rspResult(rspResult),
        .rspFlags(rspFlags), .rspErr(rspErr),
        .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .fpuOp(fpuOp), .fpuStart(fpuStart),
        .fpuMulDone(fpuMulDone), .fpuDivDone(fpuDivDone), .fpuOut(fpuOut), .fpuFlags(fpuFlags)
    );

    always #5 clock = ~clock;

    // ---------------- FPU stub ----------------
    function automatic real h2r(input logic [15:0] h);
        real v;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) return 0.0;
        v = 1.0 + real'(h[9:0]) / 1024.0;
        while (e > 15) begin v = v * 2.0; e--; end
        while (e < 15) begin v = v / 2.0; e++; end
        return v;
    endfunction

    function automatic logic [15:0] r2h(input real vin);
        real v;
        int  e;
        v = vin;
        if (v <= 0.0) return 16'h0000;
        e = 15;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v <  1.0) begin v = v * 2.0; e--; end
        return {1'b0, 5'(e), 10'($rtoi((v - 1.0) * 1024.0))};
    endfunction

    function automatic logic [15:0] stub(input logic [15:0] a, input logic [15:0] b, input fpuOp_t op);
        case (op)
            FPU_ADD: return r2h(h2r(a) + h2r(b));
            FPU_SUB: return r2h(h2r(a) - h2r(b));
            FPU_MUL: return r2h(h2r(a) * h2r(b));
            FPU_DIV: return (b == 0) ? 16'h0000 : r2h(h2r(a) / h2r(b));
            default: return a ^ b;
        endcase
    endfunction

    assign fpuOut   = stub(fpuIn1, fpuIn2, fpuOp);
    assign fpuFlags = stubFlags;

    int doneLat = 3;
    bit hangDiv = 1'b0;
    int doneCnt = -1;

    // Done pulses doneLat+1 cycles after start; the wrong done strobe is
    // pulsed one cycle earlier as a decoy.
    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            doneCnt    <= -1;
            fpuMulDone <= 1'b0;
            fpuDivDone <= 1'b0;
        end else begin
            fpuMulDone <= 1'b0;
            fpuDivDone <= 1'b0;
            if (fpuStart) doneCnt <= doneLat;
            else if (doneCnt > 0) begin
                doneCnt <= doneCnt - 1;
                if (doneCnt == 1) begin
                    if (fpuOp == FPU_MUL) fpuDivDone <= 1'b1;
                    else                  fpuMulDone <= 1'b1;
                end
            end else if (doneCnt == 0) begin
                doneCnt <= -1;
                if (fpuOp == FPU_MUL)  fpuMulDone <= 1'b1;
                else if (!hangDiv)     fpuDivDone <= 1'b1;
            end
        end
    end

    // ---------------- checking ----------------
    int nChecks = 0;
    int nFails  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        id;
        logic [15:0] res;
        logic [4:0]  flags;
        logic        err;
    } exp_t;

    exp_t sb[$];

    int cyc = 0;
    int startCnt = 0;
    int startCyc = 0;
    int mulDoneCyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (fpuStart) begin
            startCnt <= startCnt + 1;
            startCyc <= cyc;
        end
        if (fpuMulDone) mulDoneCyc <= cyc;
        if (resetN && rspValid && rspReady) begin
            if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id",    rspId,     e.id);
                chk("rsp_res",   rspResult, e.res);
                chk("rsp_flags", rspFlags,  e.flags);
                chk("rsp_err",   rspErr,    e.err);
            end
        end
    end

    // Called and returns at posedge+1; leaves valid low after acceptance.
    task automatic issue(input bit id, input logic [15:0] a, input logic [15:0] b, input fpuOp_t op);
        int n;
        bit rdy;
        n = 0;
        if (id) begin req1Valid = 1'b1; req1In1 = a; req1In2 = b; req1Op = op; end
        else    begin req0Valid = 1'b1; req0In1 = a; req0In2 = b; req0Op = op; end
        do begin
            @(negedge clock);
            n++;
            rdy = id ? req1Ready : req0Ready;
        end while (!rdy && n < 300);
        chk($sformatf("accept%0d", id), rdy, 1);
        @(posedge clock); #1;
        if (id) req1Valid = 1'b0; else req0Valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin @(negedge clock); n++; end
        chk("drain", sb.size(), 0);
        @(posedge clock); #1;
    endtask

    task automatic waitRsp(input string tag, output int rc);
        int n;
        n = 0;
        while (!rspValid && n < 200) begin @(negedge clock); n++; end
        chk(tag, rspValid, 1);
        rc = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int rc, s0, bad;
        logic [22:0] snap;

        // ---- reset state, with a request already pending ----
        req0Valid = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_outs",
            {rspValid, rspErr, fpuStart, req0Ready, req1Ready, fpuIn1, fpuIn2, fpuOp, rspResult, rspFlags, rspId}, 0);
        req0Valid = 1'b0;
        @(posedge clock); #1;
        resetN = 1'b1;

        // ---- T1: req0 ADD, latency ----
        rspReady = 1'b1;
        sb.push_back('{1'b0, 16'h4200, 5'b00001, 1'b0});
        req0Valid = 1'b1; req0In1 = 16'h3C00; req0In2 = 16'h4000; req0Op = FPU_ADD;
        @(negedge clock);
        chk("t1_rdy0", req0Ready, 1);
        chk("t1_rdy1", req1Ready, 0);
        @(posedge clock); #1;
        req0Valid = 1'b0;
        @(negedge clock);
        chk("t1_vld_c1", rspValid, 0);
        chk("t1_fpuin", {fpuIn1, fpuIn2, fpuOp}, {16'h3C00, 16'h4000, FPU_ADD});
        @(negedge clock);
        chk("t1_vld_c2", rspValid, 1);
        drain();

        // ---- T2: req1 MUL, start pulse, operand stability ----
        s0 = startCnt;
        sb.push_back('{1'b1, 16'h4600, 5'b00001, 1'b0});
        issue(1, 16'h4000, 16'h4200, FPU_MUL);
        bad = 0;
        for (int k = 0; k < 200 && !rspValid; k++) begin
            @(negedge clock);
            if ({fpuIn1, fpuIn2, fpuOp} != {16'h4000, 16'h4200, FPU_MUL}) bad++;
        end
        chk("t2_rsp", rspValid, 1);
        rc = cyc;
        chk("t2_in_stable", bad, 0);
        chk("t2_start_cnt", startCnt - s0, 1);
        chk("t2_done_lat", rc - mulDoneCyc, 1);
        drain();

        // ---- T3: fresh reset, both requesters, 3 SUBs each ----
        resetN = 1'b0;
        @(posedge clock); #1;
        resetN = 1'b1;
        stubFlags = 5'b00110;
        for (int k = 0; k < 6; k++) sb.push_back('{1'(k % 2), 16'h4000, 5'b00110, 1'b0});
        fork
            begin for (int k = 0; k < 3; k++) issue(0, 16'h4200, 16'h3C00, FPU_SUB); end
            begin for (int k = 0; k < 3; k++) issue(1, 16'h4200, 16'h3C00, FPU_SUB); end
        join
        drain();
        stubFlags = 5'b00001;

        // ---- T4: hung DIV -> watchdog, then normal DIV, then bad opcode ----
        hangDiv = 1'b1;
        sb.push_back('{1'b0, 16'h7E00, 5'b10000, 1'b1});
        issue(0, 16'h4000, 16'h4000, FPU_DIV);
        waitRsp("t4_rsp", rc);
        chk("t4_timeout_lat", rc - startCyc, TO + 1);
        drain();
        hangDiv = 1'b0;
        sb.push_back('{1'b1, 16'h4200, 5'b00001, 1'b0});
        issue(1, 16'h4200, 16'h3C00, FPU_DIV);
        drain();
        sb.push_back('{1'b0, 16'h3C42, 5'b00001, 1'b0});
        issue(0, 16'h3C00, 16'h0042, 3'd5);
        drain();

        // ---- T5: response backpressure ----
        rspReady = 1'b0;
        sb.push_back('{1'b0, 16'h4400, 5'b00001, 1'b0});
        sb.push_back('{1'b1, 16'h4000, 5'b00001, 1'b0});
        issue(0, 16'h4000, 16'h4000, FPU_MUL);
        fork
            begin
                waitRsp("t5_rsp", rc);
                snap = {rspId, rspResult, rspFlags, rspErr};
                bad = 0;
                repeat (5) begin
                    @(negedge clock);
                    if ({rspId, rspResult, rspFlags, rspErr} != snap) bad++;
                    if (req0Ready || req1Ready || !rspValid) bad++;
                end
                chk("t5_hold", bad, 0);
                @(posedge clock); #1;
                rspReady = 1'b1;
                @(negedge clock);
                chk("t5_vld_at_accept", rspValid, 1);
                @(negedge clock);
                chk("t5_vld_after", rspValid, 0);
            end
            issue(1, 16'h3C00, 16'h3C00, FPU_ADD);
        join
        drain();

        // ---- T6: asynchronous reset in the middle of a DIV wait ----
        hangDiv = 1'b1;
        issue(0, 16'h4000, 16'h4000, FPU_DIV);
        repeat (4) @(negedge clock);
        #2;
        resetN = 1'b0;
        #1;
        chk("t6_async_clr",
            {rspValid, rspErr, fpuStart, req0Ready, req1Ready, fpuIn1, fpuIn2, fpuOp, rspResult, rspFlags, rspId}, 0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        resetN  = 1'b1;
        hangDiv = 1'b0;
        repeat (TO + 4) @(negedge clock);
        chk("t6_no_rsp", rspValid, 0);
        @(posedge clock); #1;
        sb.push_back('{1'b0, 16'h4000, 5'b00001, 1'b0});
        issue(0, 16'h3C00, 16'h3C00, FPU_ADD);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/fpu_req_arbiter.md
Name: fpu_req_arbiter

Overview:
- Shares one `fpu` instance (FP_T operands, `fpuOp_t` op, start / mulDone / divDone handshake) between two independent requesters.
- Performs round-robin arbitration and sequences each operation:
  - ADD/SUB: one-cycle settle, then capture.
  - MUL/DIV: start pulse, then wait for done.
- Returns the result, status flags and requester ID on a single valid/ready response channel.
- A watchdog converts a hung MUL/DIV into an error response, so a requester is never deadlocked.

Parameters:
- FP_T, fp16_t: floating-point operand/result type; W = $bits(FP_T).
- TIMEOUT, 64: maximum cycles spent in WAIT before the watchdog fires; must be ≥ 2.
- QNAN, 16'h7E00: result returned on timeout (width W).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- resetN  in  1  asynchronous, active-low reset.
- req0Valid  in  1  requester 0 has an operation.
- req0Ready  out  1  requester 0 accepted this cycle.
- req0In1, req0In2  in  W  requester 0 operands.
- req0Op  in  $bits(fpuOp_t)  requester 0 opcode.
- req1Valid / req1Ready / req1In1 / req1In2 / req1Op: same as requester 0, for requester 1.
- rspValid  out  1  response available.
- rspReady  in  1  consumer accepts the response.
- rspId  out  1  requester that issued the operation.
- rspResult  out  W  captured fpuOut, or QNAN on timeout.
- rspFlags  out  $bits(statusFlag_t)  captured statusFlags.
- rspErr  out  1  watchdog timeout occurred.
- fpuIn1, fpuIn2  out  W  operands to the FPU, registered.
- fpuOp  out  $bits(fpuOp_t)  opcode to the FPU, registered.
- fpuStart  out  1  one-cycle start pulse for MUL/DIV.
- fpuMulDone, fpuDivDone  in  1  FPU completion.
- fpuOut  in  W  FPU result.
- fpuFlags  in  $bits(statusFlag_t)  FPU status flags.

Behaviour:
- Reset (resetN low, asynchronous):
  - state=IDLE; lastGrant=1, so requester 0 wins the first tie.
  - All outputs 0: rspValid, rspErr, fpuStart, req*Ready; fpuIn1/fpuIn2/fpuOp/rspResult/rspFlags/rspId cleared.
  - Reset during any state aborts the in-flight operation silently; no response is produced.
- States: IDLE, SETTLE, START, WAIT, RESP.
- IDLE:
  - reqXReady is combinational: asserted only in IDLE, and only for the winner.
  - Winner selection:
    - Only one requester valid: that requester wins.
    - Both valid: the requester != lastGrant wins.
  - On accept edge:
    - Latch operands/op into fpuIn1/fpuIn2/fpuOp.
    - Set rspId = winner and lastGrant = winner.
    - ADD/SUB: go to SETTLE.
    - MUL/DIV: go to START.
  - The loser sees Ready=0 and must hold its request; no request is dropped.
- SETTLE: one cycle for the combinational ADD/SUB path. On the next edge capture fpuOut/fpuFlags, set rspErr=0, go to RESP.
- START:
  - fpuStart=1 for exactly this cycle; watchdog counter cleared.
  - Next edge: go to WAIT.
- WAIT:
  - Relevant done: fpuMulDone for MUL, fpuDivDone for DIV; the other done is ignored.
  - Counter increments each cycle.
  - On the edge where relevant done=1: capture fpuOut/fpuFlags, rspErr=0, go to RESP.
  - If the counter reaches TIMEOUT-1 with done low: rspResult=QNAN, rspFlags=0 except the NV bit set, rspErr=1, go to RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - rspValid=1; rsp* are stable while rspValid && !rspReady.
  - On rspValid && rspReady: clear rspValid and go to IDLE.
  - No new request is accepted in the same cycle (one idle cycle between operations).
- fpuIn1/fpuIn2/fpuOp are held constant from accept until return to IDLE.
- Latency from accept edge to rspValid rising:
  - ADD/SUB: 2 cycles.
  - MUL/DIV: 2 cycles + FPU done latency.
- Throughput: at most one operation in flight.
- Invalid opcode (none of ADD/SUB/MUL/DIV): treated as ADD/SUB (SETTLE path), and the FPU output is returned unchanged.

Test Plan:
- Req0 ADD 3C00+4000, rspReady=1 → req0Ready in cycle 0; rspValid 2 cycles later; rspResult=4200, rspId=0, rspErr=0.
- Req1 MUL 4000×4200 → fpuStart high exactly one cycle; fpuIn* stable throughout; rspResult=4600, rspId=1, available the cycle after fpuMulDone.
- Both valid from reset, each with 3 back-to-back SUBs 4200-3C00 → grants alternate 0,1,0,1,0,1; all six results are 4000 with correct rspId.
- DIV with FPU stub never asserting fpuDivDone, TIMEOUT=8 → rspValid 8 cycles after START exit; rspResult=7E00, NV=1, rspErr=1; next request is then served normally.
- Hold rspReady=0 for 5 cycles after MUL completes → rsp* unchanged; both req*Ready stay 0; accepted on the first rspReady=1 cycle.
- Assert resetN=0 mid-WAIT of a DIV → all outputs 0 immediately (asynchronously); no response after release; a new ADD 3C00+3C00 then returns 4000.
